router_pkt_reg: RTL and testbench

//  Datapath register stage of the 1x3 router, driven by the router FSM state strobes.

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_parity_acc.sv | 26 ++
 rtl/router_pkt_reg.sv | 172 +++++++++++++++++
 tb/tb_router_pkt_reg.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: default byte/address widths, invalid-address code, header field helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package router_pkg;

    localparam int unsigned ROUTER_DATA_WIDTH = 8;
    localparam int unsigned ROUTER_ADDR_BITS  = 2;
    localparam int unsigned PAY_CNT_W         = 6;

    // All-ones destination code means "no such port"; truncated to the address width at use.
    localparam logic [31:0] ADDR_INVALID = '1;

    // Destination address field (header LSBs).
    function automatic logic [31:0] hdr_addr(input logic [31:0] h, input int unsigned ab);
        return h & ((32'd1 << ab) - 32'd1);
    endfunction

    // Payload length field (header bits above the address).
    function automatic logic [31:0] hdr_len(input logic [31:0] h, input int unsigned dw,
                                            input int unsigned ab);
        return (h >> ab) & ((32'd1 << (dw - ab)) - 32'd1);
    endfunction

    // True when the header addresses the reserved all-ones destination.
    function automatic logic addr_is_invalid(input logic [31:0] h, input int unsigned ab);
        return hdr_addr(h, ab) == (ADDR_INVALID & ((32'd1 << ab) - 32'd1));
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity accumulator for one packet (header plus payload bytes).
// Latency: 1 cycle from en/clr to the updated par value.
// Backpressure: none; the caller gates en so each byte is folded in exactly once.
module router_parity_acc import router_pkg::*; #(
    parameter int unsigned DATA_WIDTH = ROUTER_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_byte,
    output logic [DATA_WIDTH-1:0] par
);

    // Clear at the start of a packet, otherwise fold in each accepted byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            par <= '0;
        end else if (clr) begin
            par <= '0;
        end else if (en) begin
            par <= par ^ data_byte;
        end
    end

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register: header/payload/parity capture, dout to output FIFOs, parity check (optional ROUTER_LEN_CHECK_EN length check).
// Latency: 1 cycle from FSM state strobe to dout/status update.
// Backpressure: fifo_full parks the current byte in hold_byte; it is replayed on dout in the laf cycle.
module router_pkt_reg import router_pkg::*; #(
    parameter int unsigned DATA_WIDTH = ROUTER_DATA_WIDTH,
    parameter int unsigned ADDR_BITS  = ROUTER_ADDR_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_packet_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  len_err
);

    logic [DATA_WIDTH-1:0] hdr;
    logic [DATA_WIDTH-1:0] hold_byte;
    logic [DATA_WIDTH-1:0] pkt_par;
    logic [DATA_WIDTH-1:0] int_par;
    logic [DATA_WIDTH-1:0] par_byte;

    logic ld_eff;
    logic laf_eff;
    logic hdr_ok;
    logic par_cap_ld;
    logic par_cap_laf;
    logic laf_replay;
    logic par_en;

    // Decode strobes; lfd outranks ld, which outranks laf, should they ever overlap.
    always_comb begin
        ld_eff      = ld_state && !lfd_state;
        laf_eff     = laf_state && !lfd_state && !ld_state;
        hdr_ok      = detect_add && pkt_valid
                      && !addr_is_invalid(32'(data_in), ADDR_BITS);
        // pkt_valid low in a load cycle means data_in is the parity byte.
        par_cap_ld  = ld_eff && !fifo_full && !pkt_valid && !parity_done;
        // When pkt_valid dropped while full, the parked byte is the parity byte.
        par_cap_laf = laf_eff && low_packet_valid && !parity_done;
        // Otherwise the parked byte is payload and is accounted for here, once.
        laf_replay  = laf_eff && !low_packet_valid;
        par_en      = lfd_state
                      || (ld_eff && pkt_valid && !full_state && !fifo_full)
                      || laf_replay;
    end

    // Select which byte the parity accumulator folds in this cycle.
    always_comb begin
        par_byte = data_in;
        if (lfd_state) begin
            par_byte = hdr;
        end else if (laf_replay) begin
            par_byte = hold_byte;
        end
    end

    router_parity_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_acc (
        .clock     (clock),
        .reset     (reset),
        .clr       (detect_add),
        .en        (par_en),
        .data_byte (par_byte),
        .par       (int_par)
    );

    // Latch the header only when it names a real destination.
    always_ff @(posedge clock) begin
        if (reset) begin
            hdr <= '0;
        end else if (hdr_ok) begin
            hdr <= data_in;
        end
    end

    // Drive dout; a byte arriving while the FIFO is full is parked for the laf replay.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout      <= '0;
            hold_byte <= '0;
        end else if (lfd_state) begin
            dout <= hdr;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state) begin
            hold_byte <= data_in;
        end else if (laf_state) begin
            dout <= hold_byte;
        end
    end

    // Capture the parity byte once per packet and report it to the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_par     <= '0;
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (par_cap_ld) begin
            pkt_par     <= data_in;
            parity_done <= 1'b1;
        end else if (par_cap_laf) begin
            pkt_par     <= hold_byte;
            parity_done <= 1'b1;
        end
    end

    // Flag end of packet (pkt_valid low during load); a new drop beats the clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            low_packet_valid <= 1'b0;
        end else if (ld_eff && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end
    end

    // Compare computed and received parity in the check state; sticky until next header.
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (rst_int_reg && parity_done) begin
            err <= (int_par != pkt_par);
        end else if (detect_add) begin
            err <= 1'b0;
        end
    end

`ifdef ROUTER_LEN_CHECK_EN
    logic [PAY_CNT_W-1:0] pay_cnt;
    logic                 pay_acc;

    // A payload byte is accepted when it goes straight out or is replayed after full.
    always_comb begin
        pay_acc = (ld_eff && pkt_valid && !fifo_full) || laf_replay;
    end

    // Count payload bytes (saturating) and check against the header length field.
    always_ff @(posedge clock) begin
        if (reset) begin
            pay_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            if (lfd_state) begin
                pay_cnt <= '0;
            end else if (pay_acc && (pay_cnt != '1)) begin
                pay_cnt <= pay_cnt + 1'b1;
            end
            if (rst_int_reg) begin
                len_err <= (32'(pay_cnt) != hdr_len(32'(hdr), DATA_WIDTH, ADDR_BITS));
            end else if (detect_add) begin
                len_err <= 1'b0;
            end
        end
    end
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: acts as router FSM and source, checks dout stream and status against a packet-level model.
// Latency: expects each strobe's effect one clock later.
// Backpressure: exercises fifo_full mid-payload and on the parity byte.
module tb_router_pkt_reg;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       detect_add = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       parity_done;
    logic       low_packet_valid;
    logic       err;
    logic [7:0] dout;
    logic       len_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] pay_q[$];

    router_pkt_reg dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err),
        .dout             (dout),
        .len_err          (len_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    // Packet parity: XOR of header and every payload byte.
    function automatic logic [7:0] model_par(input logic [7:0] h);
        logic [7:0] p;
        p = h;
        foreach (pay_q[i]) p ^= pay_q[i];
        return p;
    endfunction

    // Length check outcome: saturating count of payload bytes against header[7:2].
    function automatic logic model_len_err(input logic [7:0] h);
        int cnt;
        cnt = (pay_q.size() > 63) ? 63 : pay_q.size();
`ifdef ROUTER_LEN_CHECK_EN
        return cnt != int'(h >> 2);
`else
        return (cnt < 0);
`endif
    endfunction

    // Send header + pay_q + parity byte; full_at = payload index that sees fifo_full (-1 none).
    task automatic send_pkt(input logic [7:0] h, input logic [7:0] par_b,
                            input int full_at, input bit drop_full);
        logic [7:0] last;
        logic       exp_err;
        logic       exp_len;
        exp_err = (model_par(h) != par_b);
        exp_len = model_len_err(h);

        idle();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = h;
        tick();
        chk1("pd_clr_on_detect", parity_done, 1'b0);
        chk1("err_clr_on_detect", err, 1'b0);
        chk1("len_err_clr_on_detect", len_err, 1'b0);

        detect_add = 1'b0;
        lfd_state  = 1'b1;
        data_in    = 8'($urandom);
        tick();
        chk8("dout_hdr", dout, h);
        last = h;
        lfd_state = 1'b0;

        foreach (pay_q[i]) begin
            ld_state  = 1'b1;
            pkt_valid = 1'b1;
            data_in   = pay_q[i];
            fifo_full = (i == full_at);
            tick();
            if (i != full_at) begin
                chk8("dout_pay", dout, pay_q[i]);
            end else begin
                chk8("dout_hold_on_full", dout, last);
                ld_state   = 1'b0;
                full_state = 1'b1;
                data_in    = 8'($urandom);
                tick();
                chk8("dout_full_state", dout, last);
                full_state = 1'b0;
                fifo_full  = 1'b0;
                laf_state  = 1'b1;
                tick();
                chk8("dout_laf_replay", dout, pay_q[i]);
                laf_state = 1'b0;
            end
            last = pay_q[i];
        end

        ld_state  = 1'b1;
        pkt_valid = 1'b0;
        data_in   = par_b;
        fifo_full = drop_full;
        tick();
        chk1("lpv_set", low_packet_valid, 1'b1);
        if (drop_full) begin
            chk8("dout_par_hold", dout, last);
            chk1("pd_wait_full", parity_done, 1'b0);
            ld_state   = 1'b0;
            full_state = 1'b1;
            data_in    = 8'($urandom);
            tick();
            full_state = 1'b0;
            fifo_full  = 1'b0;
            laf_state  = 1'b1;
            tick();
            laf_state = 1'b0;
        end
        chk8("dout_par", dout, par_b);
        chk1("pd_set", parity_done, 1'b1);

        ld_state  = 1'b0;
        fifo_full = 1'b0;
        data_in   = 8'($urandom);
        tick();
        chk1("pd_hold", parity_done, 1'b1);

        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        chk1("err_check", err, exp_err);
        chk1("lpv_clr", low_packet_valid, 1'b0);
        chk1("len_err_check", len_err, exp_len);
        tick();
        chk1("err_hold", err, exp_err);
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] p;
        int         len;
        int         npay;
        int         fa;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk8("rst_dout", dout, 8'h00);
        chk1("rst_pd", parity_done, 1'b0);
        chk1("rst_lpv", low_packet_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_len_err", len_err, 1'b0);
        reset = 1'b0;

        // Basic packet, good parity
        pay_q = '{8'h01, 8'h02, 8'h03};
        send_pkt(8'h0C, 8'h0C, -1, 1'b0);

        // Bad parity byte
        send_pkt(8'h0C, 8'hFF, -1, 1'b0);

        // FIFO full on payload byte 02
        send_pkt(8'h0C, 8'h0C, 1, 1'b0);

        // pkt_valid drops while the FIFO is full
        send_pkt(8'h0C, 8'h0C, -1, 1'b1);

        // Invalid destination or pkt_valid low: header register keeps 0C
        idle();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h0F;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        chk8("hdr_invalid_addr_ignored", dout, 8'h0C);
        idle();
        detect_add = 1'b1;
        data_in    = 8'h10;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        chk8("hdr_no_pkt_valid_ignored", dout, 8'h0C);

        // Reset mid-payload
        idle();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = 8'h11;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        lfd_state = 1'b0;
        ld_state  = 1'b1;
        data_in   = 8'hAA;
        tick();
        chk8("pre_reset_dout", dout, 8'hAA);
        reset   = 1'b1;
        data_in = 8'h55;
        tick();
        chk8("midrst_dout", dout, 8'h00);
        chk1("midrst_pd", parity_done, 1'b0);
        chk1("midrst_lpv", low_packet_valid, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk1("midrst_len_err", len_err, 1'b0);
        reset = 1'b0;
        idle();
        pay_q = '{8'h01, 8'h02, 8'h03};
        send_pkt(8'h0C, 8'h0C, -1, 1'b0);

        // Length field 4: three payload bytes, then four
        pay_q = '{8'h01, 8'h02, 8'h03};
        send_pkt(8'h10, model_par(8'h10), -1, 1'b0);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt(8'h10, model_par(8'h10), 2, 1'b0);

        // 64 payload bytes against length 63: counter must saturate
        pay_q.delete();
        for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom));
        send_pkt(8'hFC, model_par(8'hFC), -1, 1'b0);

        // Randomized packets
        for (int n = 0; n < 30; n++) begin
            len  = $urandom_range(1, 6);
            h    = 8'((len << 2) | $urandom_range(0, 2));
            npay = len + $urandom_range(0, 2) - 1;
            if (npay < 1) npay = 1;
            pay_q.delete();
            for (int i = 0; i < npay; i++) pay_q.push_back(8'($urandom));
            p = model_par(h);
            if ($urandom_range(0, 3) == 0) p = p ^ 8'(1 << $urandom_range(0, 7));
            fa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, npay - 1) : -1;
            send_pkt(h, p, fa, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
